// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
//   Shared encodings for the multicycle RV32I controller: FSM state type,
//   opcode and funct3 constants, datapath mux-select encodings, ALU control
//   codes, plus small helpers for immediate-format and branch decisions.
//   No ports (package).
package riscv_ctrl_pkg;

  // FSM states of the multicycle controller
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JALR,
    S_JAL,
    S_LUI
  } state_t;

  // Coarse ALU request from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  // Opcodes (Instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Branch funct3 values
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_MDR       = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;
  localparam logic [1:0] RES_IMMEXT    = 2'd3;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_A     = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;
  localparam logic [1:0] SRCB_ZERO = 2'd3;

  // ALUControl encodings
  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b100;
  localparam logic [2:0] ALUC_XOR = 3'b101;

  // ImmSrc encodings
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format depends only on the opcode; unknown opcodes get I.
  function automatic logic [2:0] imm_src_for(input logic [6:0] op);
    logic [2:0] imm;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      OP_LUI:    imm = IMM_U;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

  // Branch decision from the flags of A - B; unsupported funct3 never branches.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic       zero,
                                        input logic       less_than);
    logic taken;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = less_than;
      F3_BGE:  taken = ~less_than;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
//   Translates the FSM's coarse ALU request plus instruction funct fields
//   into the 3-bit ALUControl code.
// Ports
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct fields
//   funct3      in  3  Instr[14:12]
//   funct7b5    in  1  Instr[30]
//   op5         in  1  Instr[5]; 1 for R-type, 0 for I-type ALU ops
//   alu_control out 3  ALU operation select
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALUC_ADD;
      ALU_OP_SUB: alu_control = ALUC_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          // Instr[30] means sub only for R-type; for addi it is immediate bits.
          3'b000:  alu_control = (op5 && funct7b5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  alu_control = ALUC_SLT;
          3'b100:  alu_control = ALUC_XOR;
          3'b110:  alu_control = ALUC_OR;
          3'b111:  alu_control = ALUC_AND;
          default: alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM for the multicycle RV32I datapath. A Moore machine whose
//   outputs decode from the current state (ImmSrc from op, ALUControl from
//   state and funct fields); the only flag-dependent output is PCWrite in
//   BRANCH. All write enables are held low while rst is asserted.
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   op[6:0], funct3[2:0], funct7b5  instruction fields from the Instr register
//   Zero, LessThan               ALU flags, used only in BRANCH
//   PCWrite, IRWrite, RegWrite, MemWrite  register/memory write enables
//   AdrSrc                       memory address select (0 PC, 1 Result)
//   ResultSrc[1:0]               0 ALUOut, 1 MDR, 2 ALUResult, 3 ImmExt
//   ALUSrcA[1:0], ALUSrcB[1:0]   ALU operand selects
//   ALUControl[2:0], ImmSrc[2:0] ALU operation and immediate format
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       LessThan,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc
);

  state_t  state_reg;
  state_t  state_next;
  alu_op_t alu_op;

  logic pc_write_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_B;
    alu_op        = ALU_OP_ADD;

    case (state_reg)
      S_FETCH: begin
        // Read Instr at PC and advance PC by 4 in the same cycle.
        AdrSrc       = 1'b0;
        ir_write_raw = 1'b1;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
        pc_write_raw = 1'b1;
        state_next   = S_DECODE;
      end

      S_DECODE: begin
        // Precompute OldPC + imm so BRANCH/JAL find their target in ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I_ALU:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_FETCH;
        endcase
      end

      S_MEMADR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        ResultSrc  = RES_ALUOUT;
        AdrSrc     = 1'b1;
        state_next = S_MEMWB;
      end

      S_MEMWB: begin
        ResultSrc     = RES_MDR;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      S_MEMWRITE: begin
        ResultSrc     = RES_ALUOUT;
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      S_EXECR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        alu_op     = ALU_OP_FUNCT;
        state_next = S_ALUWB;
      end

      S_EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALU_OP_FUNCT;
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        ResultSrc     = RES_ALUOUT;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      S_BRANCH: begin
        // Compare A - B; the target computed in DECODE is routed from ALUOut.
        ALUSrcA      = SRCA_A;
        ALUSrcB      = SRCB_B;
        alu_op       = ALU_OP_SUB;
        ResultSrc    = RES_ALUOUT;
        pc_write_raw = branch_taken(funct3, Zero, LessThan);
        state_next   = S_FETCH;
      end

      S_JALR: begin
        // Overwrite ALUOut with A + imm, then reuse JAL for the jump and link.
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        state_next = S_JAL;
      end

      S_JAL: begin
        // PC <= ALUOut (target) while the ALU forms the link value OldPC + 4.
        ResultSrc    = RES_ALUOUT;
        pc_write_raw = 1'b1;
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        state_next   = S_ALUWB;
      end

      S_LUI: begin
        ResultSrc     = RES_IMMEXT;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

  assign ImmSrc = imm_src_for(op);

  // No architectural write may escape while reset is held, whatever the state.
  assign PCWrite  = pc_write_raw  & ~rst;
  assign IRWrite  = ir_write_raw  & ~rst;
  assign RegWrite = reg_write_raw & ~rst;
  assign MemWrite = mem_write_raw & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Self-checking bench: random instruction stream against a per-instruction
//   micro-sequence reference model, plus directed reset and corner cases.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       LessThan;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;

  int n_compared   = 0;
  int n_mismatched = 0;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .LessThan   (LessThan),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc)
  );

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc}
  logic [16:0] obs;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, ImmSrc};

  logic [3:0] writes;
  assign writes = {PCWrite, IRWrite, RegWrite, MemWrite};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BR) ||
           (o == JAL) || (o == JALR) || (o == LUI);
  endfunction

  // Cycles an instruction occupies, FETCH included.
  function automatic int instr_len(input logic [6:0] o);
    if (o == LUI || o == BR) return 3;
    if (o == RT || o == IT || o == SW || o == JAL) return 4;
    if (o == LW || o == JALR) return 5;
    return 2;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic is_r, input logic f7);
    case (f3)
      3'd0:    return (is_r && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd4;
      3'd4:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Expected outputs at cycle 'step' of an instruction.
  function automatic logic [16:0] model(input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7, input int step,
                                        input logic z, input logic lt);
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu, imm;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 0; sa = 0; sb = 0; alu = 0;
    if (o == SW) imm = 3'd1;
    else if (o == BR) imm = 3'd2;
    else if (o == JAL) imm = 3'd3;
    else if (o == LUI) imm = 3'd4;
    else imm = 3'd0;

    if (step == 0) begin
      irw = 1; pcw = 1; sb = 2; rs = 2;
    end else if (step == 1) begin
      sa = 1; sb = 1;
    end else if (o == RT || o == IT) begin
      if (step == 2) begin
        sa = 2; sb = (o == IT) ? 2'd1 : 2'd0; alu = funct_alu(f3, o == RT, f7);
      end else rw = 1;
    end else if (o == LW || o == SW) begin
      if (step == 2) begin
        sa = 2; sb = 1;
      end else if (step == 3) begin
        adr = 1; mw = (o == SW);
      end else begin
        rs = 1; rw = 1;
      end
    end else if (o == BR) begin
      sa = 2; sb = 0; alu = 3'd1;
      case (f3)
        3'b000:  pcw = z;
        3'b001:  pcw = !z;
        3'b100:  pcw = lt;
        3'b101:  pcw = !lt;
        default: pcw = 0;
      endcase
    end else if (o == LUI) begin
      rs = 3; rw = 1;
    end else begin
      // jal: step2 jump, step3 link; jalr has an extra target cycle first
      int k;
      k = (o == JALR) ? step - 1 : step;
      if (o == JALR && step == 2) begin
        sa = 2; sb = 1;
      end else if (k == 2) begin
        pcw = 1; sa = 1; sb = 2;
      end else rw = 1;
    end
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm};
  endfunction

  // Called at posedge+1 with the DUT in FETCH; returns in the same phase.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input bit rnd, input logic z, input logic lt, input string name);
    int len;
    int errs0;
    len   = instr_len(o);
    errs0 = n_mismatched;
    for (int s = 0; s < len; s++) begin
      op = o; funct3 = f3; funct7b5 = f7;
      if (rnd) begin
        Zero     = 1'($urandom_range(0, 1));
        LessThan = 1'($urandom_range(0, 1));
      end else begin
        Zero = z; LessThan = lt;
      end
      @(negedge clk);
      check($sformatf("%s op=%b f3=%b f7=%b step%0d", name, o, f3, f7, s),
            32'(obs), 32'(model(o, f3, f7, s, Zero, LessThan)));
      @(posedge clk);
      #1;
    end
    $display("%s op=%b f3=%b f7=%b cycles=%0d errors=%0d", name, o, f3, f7, len,
             n_mismatched - errs0);
  endtask

  initial begin
    logic [6:0] o;
    rst = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0; LessThan = 1'b0;

    // Power-on reset: two cycles with all writes held off.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("por_writes%0d", i), 32'(writes), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    run_instr(RT, 3'b000, 1'b1, 0, 0, 0, "sub");
    run_instr(IT, 3'b000, 1'b1, 0, 0, 0, "addi_b30");
    run_instr(LW, 3'b010, 1'b0, 0, 0, 0, "lw");
    run_instr(SW, 3'b010, 1'b0, 0, 0, 0, "sw");
    run_instr(BR, 3'b001, 1'b0, 0, 1, 0, "bne_z1");
    run_instr(BR, 3'b001, 1'b0, 0, 0, 0, "bne_z0");
    run_instr(BR, 3'b101, 1'b0, 0, 0, 1, "bge_lt1");
    run_instr(BR, 3'b010, 1'b0, 0, 1, 1, "br_bad_f3");
    run_instr(JALR, 3'b000, 1'b0, 0, 0, 0, "jalr");
    run_instr(JAL, 3'b000, 1'b0, 0, 0, 0, "jal");
    run_instr(LUI, 3'b000, 1'b0, 0, 0, 0, "lui");
    run_instr(7'b0000000, 3'b000, 1'b0, 0, 0, 0, "illegal");

    // Reset held two cycles in the middle of an R-type instruction.
    op = RT; funct3 = 3'b000; funct7b5 = 1'b0;
    @(negedge clk);
    check("mid_fetch", 32'(obs), 32'(model(RT, 3'b000, 1'b0, 0, 0, 0)));
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_decode", 32'(obs), 32'(model(RT, 3'b000, 1'b0, 1, 0, 0)));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_execr_writes", 32'(writes), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_hold_writes", 32'(writes), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(RT, 3'b110, 1'b0, 0, 0, 0, "after_rst_or");

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 8))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BR;
        5: o = JAL;
        6: o = JALR;
        7: o = LUI;
        default: begin
          o = 7'($urandom_range(0, 127));
          while (is_legal(o)) o = 7'($urandom_range(0, 127));
        end
      endcase
      run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1, 0, 0,
                $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
